mem_arb: RTL and testbench

- Two-requester memory arbiter between the core's instruction-fetch port (ifu_*) and load/store port (lsu_*), and one shared downstream memory port (mem_*).
- Handles one transaction at a time: capture, issue with valid/ready, wait for response, return it to the winner.
- Alternating priority when both requesters are pending; bounded wait via a response timeout that returns an error.

---
 rtl/mem_arb.sv | 142 ++++++++++++++
 tb/tb_mem_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-requester (IFU/LSU) arbiter onto a single downstream memory port.
// One transaction in flight; alternating priority; WAIT timeout returns an error.
module mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_reqValid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [1:0]          lsu_size,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_reqValid,
    input  logic                mem_reqReady,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [1:0]          mem_size,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_respValid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err,
    output logic                busy
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_n;
    logic             owner;
    logic             last_lsu;
    logic             err;
    logic [CNT_W-1:0] cnt;
    logic             any_req;
    logic             grant_lsu;
    logic             expired;
    logic             take_data;
    logic             take_err;

    assign any_req   = ifu_reqValid | lsu_reqValid;
    assign grant_lsu = lsu_reqValid & (~ifu_reqValid | ~last_lsu);
    assign expired   = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        take_data = 1'b0;
        take_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) state_n = ISSUE;
            end
            ISSUE: begin
                if (mem_reqReady) begin
                    take_data = mem_respValid;
                    state_n   = mem_respValid ? RESP : WAIT;
                end
            end
            WAIT: begin
                // a response arriving on the expiry cycle still wins
                if (mem_respValid) begin
                    take_data = 1'b1;
                    state_n   = RESP;
                end else if (expired) begin
                    take_err = 1'b1;
                    state_n  = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner     <= 1'b0;
            last_lsu  <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_size  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner    <= grant_lsu;
                last_lsu <= grant_lsu;
                if (grant_lsu) begin
                    mem_addr  <= lsu_addr;
                    mem_size  <= lsu_size;
                    mem_wen   <= lsu_wen;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wmask;
                end else begin
                    mem_addr  <= ifu_addr;
                    mem_size  <= 2'b10;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    mem_wmask <= '0;
                end
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT) cnt <= cnt + 1'b1;
            if (take_data || take_err) begin
                err <= take_err;
                if (owner) lsu_rdata <= take_err ? '0 : mem_rdata;
                else       ifu_rdata <= take_err ? '0 : mem_rdata;
            end
        end
    end

    assign mem_reqValid  = (state == ISSUE);
    assign busy          = (state != IDLE);
    assign ifu_respValid = (state == RESP) & ~owner;
    assign lsu_respValid = (state == RESP) & owner;
    assign bus_err       = (state == RESP) & err;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: random requesters and memory against a
// transaction-level model of arbitration order, latency and timeout.
module tb_mem_arb;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_reqValid, lsu_reqValid, lsu_wen, mem_reqReady, mem_respValid;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [1:0]  lsu_size;
    logic [3:0]  lsu_wmask;
    logic        ifu_respValid, lsu_respValid, mem_reqValid, mem_wen, bus_err, busy;
    logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wmask;

    mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clock(clk), .reset(rst_n),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
        .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          lsu;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct {
        bit          lsu;
        logic [31:0] data;
        bit          err;
        int          at;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    bit   resp_log[$];
    int   resp_cyc[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // requester state
    bit          ip = 0, lp = 0, icont = 0;
    logic [31:0] ia = 0, la = 0, lwd = 0;
    logic [1:0]  ls = 0;
    logic        lw = 0;
    logic [3:0]  lwm = 0;
    int          ipct = 0, lpct = 0;
    // memory model state
    int          rdy_pct = 100, rdy_wait = 0, lat_force = -1, mcd = 0;
    bit          mpend = 0, dforce = 0;
    logic [31:0] mdata = 0, dval = 0;
    // arbitration model
    bit          m_free = 1, m_last = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic raise_ifu(input logic [31:0] a);
        ip = 1;
        ia = a;
    endtask

    task automatic raise_lsu(input logic [31:0] a, input logic [1:0] s, input logic w,
                             input logic [31:0] wd, input logic [3:0] wm);
        lp = 1; la = a; ls = s; lw = w; lwd = wd; lwm = wm;
    endtask

    function automatic int pick_lat();
        int r;
        if (lat_force >= 0) return lat_force;
        r = int'($urandom_range(0, 9));
        if (r < 3) return 0;
        if (r < 8) return int'($urandom_range(1, T));
        return int'($urandom_range(T + 1, T + 2));
    endfunction

    task automatic step();
        req_t        e;
        rsp_t        r;
        int          lat;
        logic [31:0] d, rd;
        logic        rv, rdy;
        bit          win;
        @(negedge clk);
        if (ifu_respValid) begin
            if (icont) ia = $urandom;
            else ip = 0;
        end
        if (lsu_respValid) lp = 0;
        if (!ip && $urandom_range(0, 99) < ipct) raise_ifu($urandom);
        if (!lp && $urandom_range(0, 99) < lpct)
            raise_lsu($urandom, 2'($urandom), 1'($urandom), $urandom, 4'($urandom));
        rv = 0;
        rd = $urandom;
        if (mpend) begin
            if (mcd == 1) begin
                rv = 1; rd = mdata; mpend = 0;
            end else begin
                mcd--;
            end
        end
        rdy = ($urandom_range(0, 99) < rdy_pct);
        if (mem_reqValid) begin
            if (rdy_wait > 0) begin
                rdy = 0;
                rdy_wait--;
            end
            if (exp_req.size() == 0) begin
                bad("unexpected_req");
            end else begin
                e = exp_req[0];
                chk("req_fields", {mem_addr, mem_size, mem_wen, mem_wmask},
                    {e.addr, e.size, e.wen, e.wmask});
                chk("req_wdata", mem_wdata, e.wdata);
                if (rdy) begin
                    void'(exp_req.pop_front());
                    lat = pick_lat();
                    d = dforce ? dval : $urandom;
                    dforce = 0;
                    r.lsu = e.lsu;
                    r.err = (lat > T);
                    r.data = r.err ? 32'h0 : d;
                    r.at = cyc + 1 + (r.err ? T : lat);
                    exp_rsp.push_back(r);
                    if (lat == 0) begin
                        rv = 1; rd = d;
                    end else begin
                        mpend = 1; mcd = lat; mdata = d;
                    end
                end
            end
        end
        if (m_free && (ip || lp)) begin
            win = (ip && lp) ? !m_last : lp;
            e.lsu = win;
            if (win) begin
                e.addr = la; e.size = ls; e.wen = lw; e.wdata = lwd; e.wmask = lwm;
            end else begin
                e.addr = ia; e.size = 2'b10; e.wen = 0; e.wdata = 0; e.wmask = 0;
            end
            exp_req.push_back(e);
            m_last = win;
            m_free = 0;
        end
        if (ifu_respValid || lsu_respValid) m_free = 1;
        ifu_reqValid = ip; ifu_addr = ia;
        lsu_reqValid = lp; lsu_addr = la; lsu_size = ls;
        lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
        mem_reqReady = rdy; mem_respValid = rv; mem_rdata = rd;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((ip || lp || mpend || exp_req.size() > 0 || exp_rsp.size() > 0) && n < 200);
        if (ip || lp || mpend || exp_req.size() > 0 || exp_rsp.size() > 0)
            bad({name, "_drain_timeout"});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_reqValid"}, mem_reqValid, 0);
        chk({tag, "_resp"}, {ifu_respValid, lsu_respValid, bus_err}, 0);
        chk({tag, "_fields"}, {mem_addr, mem_size, mem_wen, mem_wmask}, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 0);
    endtask

    // response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ifu_respValid || lsu_respValid) begin
                    chk("one_resp", ifu_respValid & lsu_respValid, 0);
                    if (exp_rsp.size() == 0) begin
                        bad("unexpected_resp");
                    end else begin
                        r = exp_rsp.pop_front();
                        chk("resp_owner", lsu_respValid, r.lsu);
                        chk("resp_data", r.lsu ? lsu_rdata : ifu_rdata, r.data);
                        chk("resp_err", bus_err, r.err);
                        chk("resp_cycle", cyc, r.at);
                    end
                    resp_log.push_back(lsu_respValid);
                    resp_cyc.push_back(cyc);
                end else begin
                    chk("err_idle", bus_err, 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifu_reqValid = 0; ifu_addr = 0;
        lsu_reqValid = 0; lsu_addr = 0; lsu_size = 0;
        lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_reqReady = 0; mem_respValid = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;

        // contention right after reset: LSU, IFU, LSU, IFU
        raise_ifu(32'h8000_0100);
        raise_lsu(32'h0000_2000, 2'b10, 1'b0, 32'h0, 4'h0);
        drain("cont1");
        raise_ifu(32'h8000_0104);
        raise_lsu(32'h0000_2004, 2'b10, 1'b0, 32'h0, 4'h0);
        drain("cont2");
        chk("cont_count", resp_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < resp_log.size()) chk("cont_order", resp_log[i], (i % 2 == 0));

        // IFU-only read
        dforce = 1; dval = 32'h0000_0013;
        raise_ifu(32'h8000_0000);
        drain("ifu_only");

        // LSU store held through 3 not-ready cycles
        rdy_wait = 3;
        raise_lsu(32'h0000_1000, 2'b01, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        drain("store");

        // timeouts; late responses land in RESP and IDLE
        lat_force = T + 1;
        raise_ifu(32'h8000_0200);
        drain("timeout_ifu");
        lat_force = T + 2;
        raise_lsu(32'h0000_3000, 2'b00, 1'b0, 32'h0, 4'h0);
        drain("timeout_lsu");
        step();
        chk("busy_after_timeout", busy, 0);

        // back-to-back zero-wait IFU stream
        lat_force = 0;
        resp_cyc.delete();
        icont = 1;
        raise_ifu(32'h8000_1000);
        repeat (30) step();
        icont = 0;
        drain("b2b");
        chk("b2b_enough", resp_cyc.size() >= 10, 1);
        for (int i = 1; i < resp_cyc.size(); i++)
            chk("b2b_gap", resp_cyc[i] - resp_cyc[i-1], 3);

        // reset during WAIT
        lat_force = T + 2;
        raise_lsu(32'h0000_4000, 2'b10, 1'b0, 32'h0, 4'h0);
        n = 0;
        while (exp_rsp.size() == 0 && n < 20) begin
            step();
            n++;
        end
        if (exp_rsp.size() == 0) bad("midwait_accept_timeout");
        step();
        #2 rst_n = 0;
        #1 chk_zero("async_reset");
        exp_req.delete(); exp_rsp.delete();
        mpend = 0; ip = 0; lp = 0; m_free = 1; m_last = 0;
        ifu_reqValid = 0; lsu_reqValid = 0; mem_respValid = 0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_resp", {ifu_respValid, lsu_respValid}, 0);
        end
        rst_n = 1;
        lat_force = 2;
        raise_lsu(32'h0000_5000, 2'b10, 1'b1, 32'h1234_5678, 4'hF);
        drain("post_reset");

        // randomized traffic
        lat_force = -1; rdy_pct = 70; ipct = 30; lpct = 30;
        n = resp_log.size();
        repeat (1500) step();
        ipct = 0; lpct = 0; rdy_pct = 100;
        drain("random");
        chk("random_progress", (resp_log.size() - n) > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
